// File: rtl/i_ref_dac_spi_if.sv
`default_nettype none
// ============================================================================
//  Module   : i_ref_dac_spi_if
//  Purpose  : Bundles the control-side inputs (enable, i_ref) with the SPI
//             pins and status flags of the reference-current DAC writer.
//  Modports : master - the DAC writer (consumes enable/i_ref, drives the rest)
//             slave  - the environment around it (control loop + DAC pins)
//  Signals  : enable, i_ref[BUS_WIDTH], sclk, mosi, cs_n, busy, frame_done,
//             sent_code[BUS_WIDTH]
//  Revision : 1.0 - initial release
// ============================================================================
interface i_ref_dac_spi_if #(
  parameter int BUS_WIDTH = 10
) ();
  logic                 enable;
  logic [BUS_WIDTH-1:0] i_ref;
  logic                 sclk;
  logic                 mosi;
  logic                 cs_n;
  logic                 busy;
  logic                 frame_done;
  logic [BUS_WIDTH-1:0] sent_code;

  modport master (
    input  enable, i_ref,
    output sclk, mosi, cs_n, busy, frame_done, sent_code
  );

  modport slave (
    output enable, i_ref,
    input  sclk, mosi, cs_n, busy, frame_done, sent_code
  );
endinterface
`default_nettype wire

// File: rtl/i_ref_dac_spi.sv
`default_nettype none
// ============================================================================
//  Module   : i_ref_dac_spi
//  Purpose  : Writes the i_ref code to the reference-current DAC over a
//             write-only SPI link (mode 0, MSB first). A frame
//             {CMD, i_ref, zero pad} goes out after reset and whenever the
//             code differs from the last one sent.
//  Ports    : clk  - system clock, rising edge
//             rst  - asynchronous reset, active low
//             bus  - master modport: enable, i_ref in; sclk, mosi, cs_n,
//                    busy, frame_done, sent_code out
//  Revision : 1.0 - initial release
// ============================================================================
module i_ref_dac_spi #(
  parameter int                  BUS_WIDTH = 10,
  parameter int                  DAC_WIDTH = 16,
  parameter int                  CMD_BITS  = 4,
  parameter logic [CMD_BITS-1:0] CMD       = 4'b0011,
  parameter int                  SCLK_DIV  = 2,
  parameter int                  CS_GAP    = 4
) (
  input  logic            clk,
  input  logic            rst,
  i_ref_dac_spi_if.master bus
);

  localparam int PAD     = DAC_WIDTH - CMD_BITS - BUS_WIDTH;
  localparam int DIV_MAX = (SCLK_DIV > CS_GAP) ? SCLK_DIV : CS_GAP;
  localparam int DIV_W   = $clog2(DIV_MAX + 1);
  localparam int BIT_W   = $clog2(DAC_WIDTH + 1);

  localparam logic [DIV_W-1:0] SCLK_END = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_END  = DIV_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DAC_WIDTH);

  generate
    if ((DAC_WIDTH < CMD_BITS + BUS_WIDTH) || (SCLK_DIV < 1) || (CS_GAP < 1)) begin : g_param_check
      $error("i_ref_dac_spi: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_TAIL     = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  state_t               state_q,      state_d;
  logic [DIV_W-1:0]     div_cnt_q,    div_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q,    bit_cnt_d;
  logic [DAC_WIDTH-1:0] shreg_q,      shreg_d;
  logic [BUS_WIDTH-1:0] code_q,       code_d;
  logic [BUS_WIDTH-1:0] sent_code_q,  sent_code_d;
  logic                 sent_valid_q, sent_valid_d;
  logic                 sclk_q,       sclk_d;
  logic                 mosi_q,       mosi_d;
  logic                 cs_n_q,       cs_n_d;
  logic                 busy_q,       busy_d;
  logic                 frame_done_q, frame_done_d;

  logic [DAC_WIDTH-1:0] frame_word;
  logic                 start_frame;

  // Zero-extend {CMD, code} to the frame width, then push it to the top so
  // the pad lands in the LSBs (works for a zero-width pad as well).
  assign frame_word  = DAC_WIDTH'({CMD, bus.i_ref}) << PAD;
  assign start_frame = bus.enable && (!sent_valid_q || (bus.i_ref != sent_code_q));

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    code_d       = code_q;
    sent_code_d  = sent_code_q;
    sent_valid_d = sent_valid_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    cs_n_d       = cs_n_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_frame) begin
          shreg_d   = frame_word;
          code_d    = bus.i_ref;
          mosi_d    = frame_word[DAC_WIDTH-1];
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (div_cnt_q == SCLK_END) begin
          div_cnt_d = '0;
          sclk_d    = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = ST_SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      ST_SHIFT_HI: begin
        if (div_cnt_q == SCLK_END) begin
          div_cnt_d = '0;
          sclk_d    = 1'b0;
          // bit_cnt counts high phases already entered; the last one
          // falls straight into the tail instead of another low phase.
          if (bit_cnt_q == BIT_LAST) begin
            mosi_d  = 1'b0;
            state_d = ST_TAIL;
          end else begin
            shreg_d = {shreg_q[DAC_WIDTH-2:0], 1'b0};
            mosi_d  = shreg_q[DAC_WIDTH-2];
            state_d = ST_SHIFT_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      ST_SHIFT_LO: begin
        if (div_cnt_q == SCLK_END) begin
          div_cnt_d = '0;
          sclk_d    = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = ST_SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      ST_TAIL: begin
        if (div_cnt_q == SCLK_END) begin
          div_cnt_d    = '0;
          cs_n_d       = 1'b1;
          frame_done_d = 1'b1;
          sent_code_d  = code_q;
          sent_valid_d = 1'b1;
          state_d      = ST_GAP;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (div_cnt_q == GAP_END) begin
          div_cnt_d = '0;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      code_q       <= '0;
      sent_code_q  <= '0;
      sent_valid_q <= 1'b0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      code_q       <= code_d;
      sent_code_q  <= sent_code_d;
      sent_valid_q <= sent_valid_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.sclk       = sclk_q;
  assign bus.mosi       = mosi_q;
  assign bus.cs_n       = cs_n_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sent_code  = sent_code_q;

endmodule
`default_nettype wire

// File: tb/tb_i_ref_dac_spi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i_ref_dac_spi
//  Purpose  : Self-checking bench for i_ref_dac_spi. Two instances: default
//             timing (index 0) and SCLK_DIV=1 / CS_GAP=1 (index 1). A
//             cycle-offset model predicts every output each cycle; directed
//             scenarios pin literal frame words and timings, then random
//             i_ref/enable/reset traffic runs against the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i_ref_dac_spi;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       en [2];
  logic [9:0] ir [2];

  int sdiv [2] = '{2, 1};
  int sgap [2] = '{4, 1};

  i_ref_dac_spi_if #(.BUS_WIDTH(10)) bus0 ();
  i_ref_dac_spi_if #(.BUS_WIDTH(10)) bus1 ();

  assign bus0.enable = en[0];
  assign bus0.i_ref  = ir[0];
  assign bus1.enable = en[1];
  assign bus1.i_ref  = ir[1];

  i_ref_dac_spi #(.BUS_WIDTH(10), .DAC_WIDTH(16), .CMD_BITS(4), .CMD(4'b0011),
                  .SCLK_DIV(2), .CS_GAP(4))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));

  i_ref_dac_spi #(.BUS_WIDTH(10), .DAC_WIDTH(16), .CMD_BITS(4), .CMD(4'b0011),
                  .SCLK_DIV(1), .CS_GAP(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic       o_cs [2], o_sclk [2], o_mosi [2], o_fd [2], o_busy [2];
  logic [9:0] o_sc [2];
  assign o_cs[0] = bus0.cs_n;   assign o_cs[1] = bus1.cs_n;
  assign o_sclk[0] = bus0.sclk; assign o_sclk[1] = bus1.sclk;
  assign o_mosi[0] = bus0.mosi; assign o_mosi[1] = bus1.mosi;
  assign o_fd[0] = bus0.frame_done; assign o_fd[1] = bus1.frame_done;
  assign o_busy[0] = bus0.busy; assign o_busy[1] = bus1.busy;
  assign o_sc[0] = bus0.sent_code; assign o_sc[1] = bus1.sent_code;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame word: command 0011 in the top nibble, code above two pad bits.
  function automatic logic [15:0] frame_of(input logic [9:0] c);
    return 16'h3000 | (16'(c) << 2);
  endfunction

  // ---------------- reference model: frame as cycle offset k ----------------
  // k=0 idle; k=1..33*D cs_n low; k=33*D+1..33*D+G gap (first = frame_done).
  int          mk    [2] = '{0, 0};
  logic [15:0] mword [2];
  logic [9:0]  mcode [2];
  logic [9:0]  msc   [2] = '{10'd0, 10'd0};
  logic        msv   [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst) begin
    for (int d = 0; d < 2; d++) begin
      int len;
      len = (2 * DW + 1) * sdiv[d];
      if (!rst) begin
        mk[d] = 0; msc[d] = '0; msv[d] = 1'b0;
      end else if (mk[d] == 0) begin
        if (en[d] && (!msv[d] || ir[d] != msc[d])) begin
          mword[d] = frame_of(ir[d]);
          mcode[d] = ir[d];
          mk[d]    = 1;
        end
      end else if (mk[d] == len + sgap[d]) begin
        mk[d] = 0;
      end else begin
        mk[d]++;
        if (mk[d] == len + 1) begin
          msc[d] = mcode[d];
          msv[d] = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int len, p;
      logic e_cs, e_busy, e_sclk, e_mosi, e_fd;
      len = (2 * DW + 1) * sdiv[d];
      e_cs = 1'b1; e_busy = 1'b0; e_sclk = 1'b0; e_mosi = 1'b0; e_fd = 1'b0;
      if (mk[d] >= 1 && mk[d] <= len) begin
        p      = (mk[d] - 1) / sdiv[d];
        e_cs   = 1'b0;
        e_busy = 1'b1;
        e_sclk = (p % 2) == 1;
        e_mosi = (p == 2 * DW) ? 1'b0 : mword[d][DW - 1 - p / 2];
      end else if (mk[d] > len) begin
        e_busy = 1'b1;
        e_fd   = (mk[d] == len + 1);
      end
      chk($sformatf("d%0d.cs_n", d),       int'(o_cs[d]),   int'(e_cs));
      chk($sformatf("d%0d.busy", d),       int'(o_busy[d]), int'(e_busy));
      chk($sformatf("d%0d.sclk", d),       int'(o_sclk[d]), int'(e_sclk));
      chk($sformatf("d%0d.mosi", d),       int'(o_mosi[d]), int'(e_mosi));
      chk($sformatf("d%0d.frame_done", d), int'(o_fd[d]),   int'(e_fd));
      chk($sformatf("d%0d.sent_code", d),  int'(o_sc[d]),   int'(msc[d]));
    end
  end

  // ---------------- bus monitor: frames as seen by the DAC ----------------
  logic        pcs   [2] = '{1'b1, 1'b1};
  logic        psclk [2] = '{1'b0, 1'b0};
  logic [15:0] cap   [2];
  int          lowc  [2] = '{0, 0};
  int          highc [2] = '{0, 0};
  int          nstart[2] = '{0, 0};
  int          ndone [2] = '{0, 0};
  logic [15:0] lastword [2];
  int          lastlow  [2];
  logic [15:0] wq1 [$];
  int          lq1 [$];
  int          gq1 [$];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!o_cs[d]) begin
        if (pcs[d]) begin
          nstart[d]++;
          if (d == 1) gq1.push_back(highc[d]);
          cap[d]  = '0;
          lowc[d] = 0;
        end
        lowc[d]++;
        if (o_sclk[d] && !psclk[d]) cap[d] = {cap[d][14:0], o_mosi[d]};
      end else begin
        if (!pcs[d]) highc[d] = 0;
        highc[d]++;
      end
      if (o_fd[d]) begin
        ndone[d]++;
        lastword[d] = cap[d];
        lastlow[d]  = lowc[d];
        if (d == 1) begin
          wq1.push_back(cap[d]);
          lq1.push_back(lowc[d]);
        end
      end
      pcs[d]   = o_cs[d];
      psclk[d] = o_sclk[d];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int d, input int target, input string nm);
    int n = 0;
    while (ndone[d] < target && n < 400) begin @(posedge clk); #1; n++; end
    chk(nm, int'(ndone[d] >= target), 1);
  endtask

  task automatic wait_start(input int d, input int target, input string nm);
    int n = 0;
    while (nstart[d] < target && n < 400) begin @(posedge clk); #1; n++; end
    chk(nm, int'(nstart[d] >= target), 1);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, rises;
    logic prev;
    en[0] = 1'b1; ir[0] = 10'h3FF;
    en[1] = 1'b0; ir[1] = 10'h000;
    rst = 1'b0;
    cyc(3);
    chk("rst cs_n", int'(bus0.cs_n), 1);
    chk("rst sclk", int'(bus0.sclk), 0);
    chk("rst mosi", int'(bus0.mosi), 0);
    chk("rst busy", int'(bus0.busy), 0);
    chk("rst frame_done", int'(bus0.frame_done), 0);
    chk("rst sent_code", int'(bus0.sent_code), 0);
    rst = 1'b1;

    // 1: first frame after reset
    wait_done(0, 1, "t1 frame timeout");
    chk("t1 word", int'(lastword[0]), 'h3FFC);
    chk("t1 cs_low", lastlow[0], 66);
    cyc(1);
    chk("t1 sent_code", int'(bus0.sent_code), 'h3FF);

    // 2: code unchanged, no traffic
    s0 = nstart[0];
    cyc(500);
    chk("t2 no frame", nstart[0], s0);
    chk("t2 busy", int'(bus0.busy), 0);

    // 3: code changes mid-frame; only the final value follows
    s0 = nstart[0]; d0 = ndone[0];
    ir[0] = 10'h0F0;
    wait_start(0, s0 + 1, "t3 start timeout");
    cyc(20); ir[0] = 10'h155;
    cyc(20); ir[0] = 10'h000;
    wait_done(0, d0 + 1, "t3 frame1 timeout");
    chk("t3 word1", int'(lastword[0]), 'h33C0);
    wait_done(0, d0 + 2, "t3 frame2 timeout");
    chk("t3 word2", int'(lastword[0]), 'h3000);
    cyc(300);
    chk("t3 frame count", nstart[0], s0 + 2);

    // 4: enable gates new frames
    en[0] = 1'b0; ir[0] = 10'h155;
    s0 = nstart[0]; d0 = ndone[0];
    cyc(100);
    chk("t4 disabled", nstart[0], s0);
    en[0] = 1'b1;
    chk("t4 cs_n before edge", int'(bus0.cs_n), 1);
    cyc(1);
    chk("t4 cs_n one cycle later", int'(bus0.cs_n), 0);
    wait_done(0, d0 + 1, "t4 frame timeout");
    chk("t4 word", int'(lastword[0]), 'h3554);

    // 5: reset at the 8th sclk rise, then full resend
    ir[0] = 10'h2C3;
    rises = 0; prev = bus0.sclk;
    for (int n = 0; n < 400 && rises < 8; n++) begin
      @(posedge clk); #1;
      if (bus0.sclk && !prev) rises++;
      prev = bus0.sclk;
    end
    chk("t5 eight rises", rises, 8);
    rst = 1'b0;
    #1;
    chk("t5 cs_n", int'(bus0.cs_n), 1);
    chk("t5 sclk", int'(bus0.sclk), 0);
    chk("t5 busy", int'(bus0.busy), 0);
    cyc(2);
    rst = 1'b1;
    d0 = ndone[0];
    wait_done(0, d0 + 1, "t5 frame timeout");
    chk("t5 word", int'(lastword[0]), 'h3B0C);
    chk("t5 cs_low", lastlow[0], 66);

    // 6: fast instance, back-to-back codes
    en[1] = 1'b1; ir[1] = 10'h001;
    wait_start(1, 1, "t6 start1 timeout");
    ir[1] = 10'h3FF;
    wait_start(1, 2, "t6 start2 timeout");
    ir[1] = 10'h200;
    wait_done(1, 3, "t6 done timeout");
    chk("t6 frames", wq1.size(), 3);
    if (wq1.size() >= 3 && gq1.size() >= 3) begin
      chk("t6 word1", int'(wq1[0]), 'h3004);
      chk("t6 word2", int'(wq1[1]), 'h3FFC);
      chk("t6 word3", int'(wq1[2]), 'h3800);
      chk("t6 low1", lq1[0], 33);
      chk("t6 low2", lq1[1], 33);
      chk("t6 low3", lq1[2], 33);
      chk("t6 gap2", gq1[1], 2);
      chk("t6 gap3", gq1[2], 2);
    end

    // random traffic against the model
    for (int n = 0; n < 5000; n++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 29) == 0) begin
          case ($urandom_range(0, 3))
            0:       ir[d] = 10'h3FF;
            1:       ir[d] = 10'h000;
            2:       ir[d] = 10'h155;
            default: ir[d] = 10'($urandom);
          endcase
        end
        if ($urandom_range(0, 299) == 0) en[d] = ~en[d];
      end
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b0;
        cyc($urandom_range(1, 3));
        rst = 1'b1;
      end
      cyc(1);
    end
    en[0] = 1'b1; en[1] = 1'b1;
    cyc(300);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
